// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, lane vector types and round/saturate helper for the final FFT stage
package fft_pkg;

    localparam int DIN_DEF    = 15;
    localparam int ARRAY_DEF  = 16;
    localparam int DOUT_DEF   = 16;
    localparam int BLOCKS_DEF = 32;

    typedef logic [ARRAY_DEF-1:0][DIN_DEF-1:0]  din_vec_t;
    typedef logic [ARRAY_DEF-1:0][DOUT_DEF-1:0] dout_vec_t;

    typedef struct packed {
        logic [31:0] value;
        logic        clip;
    } sat_t;

    // Rounds half-up before the arithmetic shift, then clamps to a signed dout-bit range.
    function automatic sat_t sat_round(input logic signed [31:0] value, input int shift, input int dout);
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sat_t               s;
        r  = (shift > 0) ? ((value + (32'sd1 <<< (shift - 1))) >>> shift) : value;
        hi = (32'sd1 <<< (dout - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dout - 1));
        s.clip  = (r > hi) || (r < lo);
        s.value = (r > hi) ? hi : ((r < lo) ? lo : r);
        return s;
    endfunction

endpackage

// File: rtl/fft_stage_8_bf2_lane.sv
// rtl/fft_stage_8_bf2_lane.sv - one distance-1 lane pair: add/sub, then round, saturate and flag clipping
module fft_bf2_lane
    import fft_pkg::*;
#(
    parameter int DIN   = DIN_DEF,
    parameter int DOUT  = DOUT_DEF,
    parameter int SHIFT = 0
) (
    input  logic signed [DIN-1:0]  i_x0,
    input  logic signed [DIN-1:0]  i_x1,
    output logic signed [DIN:0]    o_y0,
    output logic signed [DIN:0]    o_y1,
    input  logic signed [DIN:0]    i_y0,
    input  logic signed [DIN:0]    i_y1,
    output logic signed [DOUT-1:0] o_r0,
    output logic signed [DOUT-1:0] o_r1,
    output logic                   o_clip
);

    sat_t w_s0;
    sat_t w_s1;
    logic w_unused;

    // Butterfly half feeds the S2 register; round/saturate half reads it back.
    assign o_y0 = {i_x0[DIN-1], i_x0} + {i_x1[DIN-1], i_x1};
    assign o_y1 = {i_x0[DIN-1], i_x0} - {i_x1[DIN-1], i_x1};

    assign w_s0   = sat_round(32'(i_y0), SHIFT, DOUT);
    assign w_s1   = sat_round(32'(i_y1), SHIFT, DOUT);
    assign o_r0   = w_s0.value[DOUT-1:0];
    assign o_r1   = w_s1.value[DOUT-1:0];
    assign o_clip = w_s0.clip | w_s1.clip;

    assign w_unused = ^{w_s0.value[31:DOUT], w_s1.value[31:DOUT]};

endmodule

// File: rtl/fft_stage_8.sv
// rtl/fft_stage_8.sv - final radix-2 stage: 3-deep pipeline, frame tagging and sticky overflow
module fft_stage_8
    import fft_pkg::*;
#(
    parameter int DIN    = DIN_DEF,
    parameter int ARRAY  = ARRAY_DEF,
    parameter int DOUT   = DOUT_DEF,
    parameter int SHIFT  = 0,
    parameter int BLOCKS = BLOCKS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic [ARRAY-1:0][DIN-1:0]   din_re,
    input  logic [ARRAY-1:0][DIN-1:0]   din_im,
    input  logic                        ovf_clr,
    output logic                        valid_out,
    output logic [ARRAY-1:0][DOUT-1:0]  dout_re,
    output logic [ARRAY-1:0][DOUT-1:0]  dout_im,
    output logic                        frame_start,
    output logic                        frame_last,
    output logic                        ovf_sticky
);

    localparam int FW = $clog2(BLOCKS);

    logic [ARRAY-1:0][DIN-1:0]  r_s1_re, r_s1_im;
    logic [ARRAY-1:0][DIN:0]    r_s2_re, r_s2_im;
    logic [ARRAY-1:0][DOUT-1:0] r_s3_re, r_s3_im;
    logic                       r_v1, r_v2, r_v3;
    logic [FW-1:0]              r_fcnt;
    logic                       r_ovf;

    logic [ARRAY-1:0][DIN:0]    w_y_re, w_y_im;
    logic [ARRAY-1:0][DOUT-1:0] w_r_re, w_r_im;
    logic [ARRAY-1:0]           w_clip;

    for (genvar k = 0; k < ARRAY / 2; k++) begin : g_pair
        fft_bf2_lane #(.DIN(DIN), .DOUT(DOUT), .SHIFT(SHIFT)) u_re (
            .i_x0   (r_s1_re[2*k]),
            .i_x1   (r_s1_re[2*k+1]),
            .o_y0   (w_y_re[2*k]),
            .o_y1   (w_y_re[2*k+1]),
            .i_y0   (r_s2_re[2*k]),
            .i_y1   (r_s2_re[2*k+1]),
            .o_r0   (w_r_re[2*k]),
            .o_r1   (w_r_re[2*k+1]),
            .o_clip (w_clip[2*k])
        );
        fft_bf2_lane #(.DIN(DIN), .DOUT(DOUT), .SHIFT(SHIFT)) u_im (
            .i_x0   (r_s1_im[2*k]),
            .i_x1   (r_s1_im[2*k+1]),
            .o_y0   (w_y_im[2*k]),
            .o_y1   (w_y_im[2*k+1]),
            .i_y0   (r_s2_im[2*k]),
            .i_y1   (r_s2_im[2*k+1]),
            .o_r0   (w_r_im[2*k]),
            .o_r1   (w_r_im[2*k+1]),
            .o_clip (w_clip[2*k+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_re <= '0;
            r_s1_im <= '0;
            r_s2_re <= '0;
            r_s2_im <= '0;
            r_s3_re <= '0;
            r_s3_im <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_fcnt  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_v1 <= valid_in;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            // Data stages only move with their valid so idle cycles hold the last result.
            if (valid_in) begin
                r_s1_re <= din_re;
                r_s1_im <= din_im;
            end
            if (r_v1) begin
                r_s2_re <= w_y_re;
                r_s2_im <= w_y_im;
            end
            if (r_v2) begin
                r_s3_re <= w_r_re;
                r_s3_im <= w_r_im;
            end
            if (r_v3) begin
                r_fcnt <= r_fcnt + FW'(1);
            end
            // A new clip outranks a coincident clear.
            if (r_v2 && (|w_clip)) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign valid_out   = r_v3;
    assign dout_re     = r_s3_re;
    assign dout_im     = r_s3_im;
    assign frame_start = r_v3 && (r_fcnt == '0);
    assign frame_last  = r_v3 && (r_fcnt == FW'(BLOCKS - 1));
    assign ovf_sticky  = r_ovf;

endmodule

// File: tb/tb_fft_stage_8.sv
// tb/tb_fft_stage_8.sv - scoreboard bench: default, SHIFT=1 and DOUT=15 instances of fft_stage_8
module tb_fft_stage_8;
    import fft_pkg::*;

    typedef logic [15:0][15:0] ovec_t;
    typedef struct packed {
        ovec_t re;
        ovec_t im;
        logic  fs;
        logic  fl;
    } exp_t;

    localparam int NBLK = 32;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     ovf_clr = 1'b0;
    logic     valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    din_vec_t din_re = '0, din_im = '0;

    logic              vo_a, vo_b, vo_c, fs_a, fs_b, fs_c, fl_a, fl_b, fl_c, ovf_a, ovf_b, ovf_c;
    ovec_t             re_a, im_a, re_b, im_b, ext_re_c, ext_im_c;
    logic [15:0][14:0] re_c, im_c;

    int   checks = 0;
    int   failures = 0;
    exp_t q_a[$], q_b[$], q_c[$];
    int   sent[3] = '{0, 0, 0};

    din_vec_t vr, vi;
    ovec_t    er, ei;

    always #5 clk = ~clk;

    fft_stage_8 u_a (
        .clk(clk), .rst(rst), .valid_in(valid_a), .din_re(din_re), .din_im(din_im), .ovf_clr(ovf_clr),
        .valid_out(vo_a), .dout_re(re_a), .dout_im(im_a), .frame_start(fs_a), .frame_last(fl_a),
        .ovf_sticky(ovf_a)
    );
    fft_stage_8 #(.SHIFT(1)) u_b (
        .clk(clk), .rst(rst), .valid_in(valid_b), .din_re(din_re), .din_im(din_im), .ovf_clr(ovf_clr),
        .valid_out(vo_b), .dout_re(re_b), .dout_im(im_b), .frame_start(fs_b), .frame_last(fl_b),
        .ovf_sticky(ovf_b)
    );
    fft_stage_8 #(.DOUT(15)) u_c (
        .clk(clk), .rst(rst), .valid_in(valid_c), .din_re(din_re), .din_im(din_im), .ovf_clr(ovf_clr),
        .valid_out(vo_c), .dout_re(re_c), .dout_im(im_c), .frame_start(fs_c), .frame_last(fl_c),
        .ovf_sticky(ovf_c)
    );

    always_comb begin
        ext_re_c = '0;
        ext_im_c = '0;
        for (int i = 0; i < 16; i++) begin
            ext_re_c[i] = {re_c[i][14], re_c[i]};
            ext_im_c[i] = {im_c[i][14], im_c[i]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", n, act, exp);
        end
    endtask

    task automatic mon(input int inst, input ovec_t re, input ovec_t im, input logic fs, input logic fl);
        exp_t e;
        logic empty;
        empty = 1'b0;
        e = '0;
        case (inst)
            0: if (q_a.size() == 0) empty = 1'b1; else e = q_a.pop_front();
            1: if (q_b.size() == 0) empty = 1'b1; else e = q_b.pop_front();
            default: if (q_c.size() == 0) empty = 1'b1; else e = q_c.pop_front();
        endcase
        checks++;
        if (empty) begin
            failures++;
            $display("FAIL unexpected_output inst=%0d got valid_out=1 want no output", inst);
        end else begin
            if ({re, im} !== {e.re, e.im}) begin
                failures++;
                $display("FAIL data inst=%0d got re=%h im=%h want re=%h im=%h", inst, re, im, e.re, e.im);
            end
            checks++;
            if ({fs, fl} !== {e.fs, e.fl}) begin
                failures++;
                $display("FAIL frame_tags inst=%0d got start/last=%b%b want %b%b", inst, fs, fl, e.fs, e.fl);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (vo_a) mon(0, re_a, im_a, fs_a, fl_a);
            if (vo_b) mon(1, re_b, im_b, fs_b, fl_b);
            if (vo_c) mon(2, ext_re_c, ext_im_c, fs_c, fl_c);
        end
    end

    function automatic din_vec_t vec2(input int a, input int b);
        din_vec_t v;
        v = '0;
        v[0] = 15'(a);
        v[1] = 15'(b);
        return v;
    endfunction

    function automatic ovec_t ovec2(input int a, input int b);
        ovec_t v;
        v = '0;
        v[0] = 16'(a);
        v[1] = 16'(b);
        return v;
    endfunction

    function automatic din_vec_t rvec();
        din_vec_t v;
        for (int i = 0; i < 16; i++) v[i] = 15'($urandom_range(32767, 0));
        return v;
    endfunction

    function automatic int rsat(input int y, input int sh, input int dw);
        int r, hi, lo;
        r  = (sh > 0) ? ((y + (1 <<< (sh - 1))) >>> sh) : y;
        hi = (1 <<< (dw - 1)) - 1;
        lo = -(1 <<< (dw - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic model(input int inst, input din_vec_t r, input din_vec_t i, output ovec_t o_re, output ovec_t o_im);
        int sh, dw, a, b;
        sh = (inst == 1) ? 1 : 0;
        dw = (inst == 2) ? 15 : 16;
        for (int k = 0; k < 8; k++) begin
            a = $signed(r[2*k]);
            b = $signed(r[2*k+1]);
            o_re[2*k]   = 16'(rsat(a + b, sh, dw));
            o_re[2*k+1] = 16'(rsat(a - b, sh, dw));
            a = $signed(i[2*k]);
            b = $signed(i[2*k+1]);
            o_im[2*k]   = 16'(rsat(a + b, sh, dw));
            o_im[2*k+1] = 16'(rsat(a - b, sh, dw));
        end
    endtask

    task automatic issue(input int inst, input din_vec_t r, input din_vec_t i, input ovec_t o_re, input ovec_t o_im);
        exp_t e;
        e.re = o_re;
        e.im = o_im;
        e.fs = ((sent[inst] % NBLK) == 0);
        e.fl = ((sent[inst] % NBLK) == NBLK - 1);
        sent[inst]++;
        case (inst)
            0: begin q_a.push_back(e); valid_a = 1'b1; end
            1: begin q_b.push_back(e); valid_b = 1'b1; end
            default: begin q_c.push_back(e); valid_c = 1'b1; end
        endcase
        din_re = r;
        din_im = i;
        tick();
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
    endtask

    task automatic issue_rand(input int inst, input int max_gap);
        din_vec_t r, i;
        ovec_t o_re, o_im;
        r = rvec();
        i = rvec();
        model(inst, r, i, o_re, o_im);
        issue(inst, r, i, o_re, o_im);
        repeat ($urandom_range(max_gap, 0)) tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_pending", q_a.size() + q_b.size() + q_c.size(), 0);
        q_a.delete();
        q_b.delete();
        q_c.delete();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("reset_valid_out", vo_a, 0);
        chk("reset_dout", |{re_a, im_a, re_c}, 0);
        chk("reset_tags_ovf", |{fs_a, fl_a, ovf_a, ovf_c}, 0);
        rst = 1'b0;
        tick();

        // Lanes 0/1 = (100,-20): exact latency and single-cycle valid.
        issue(0, vec2(100, -20), vec2(100, -20), ovec2(80, 120), ovec2(80, 120));
        tick();
        chk("latency_cycle2_valid", vo_a, 0);
        tick();
        chk("latency_cycle3_valid", vo_a, 1);
        chk("latency_cycle3_lane0", re_a[0], 80);
        tick();
        chk("valid_one_cycle", vo_a, 0);
        drain();

        // Reset with vectors in flight.
        din_re = rvec();
        din_im = rvec();
        valid_a = 1'b1;
        tick();
        tick();
        chk("pre_rst_hold_lane1", re_a[1], 120);
        rst = 1'b1;
        #1;
        valid_a = 1'b0;
        chk("rst_async_valid", vo_a, 0);
        chk("rst_async_dout", |{re_a, im_a}, 0);
        chk("rst_async_tags", |{fs_a, fl_a}, 0);
        q_a.delete();
        sent = '{0, 0, 0};
        tick();
        rst = 1'b0;
        tick();
        issue(0, vec2(1, 2), vec2(-5, 5), ovec2(3, -1), ovec2(0, -10));
        drain();

        // SHIFT=1 rounding, both signs.
        issue(1, vec2(3, 0), vec2(3, 0), ovec2(2, 2), ovec2(2, 2));
        issue(1, vec2(-3, 0), vec2(-3, 0), ovec2(-1, -1), ovec2(-1, -1));
        issue(1, vec2(-1, 0), vec2(5, -2), ovec2(0, 0), ovec2(2, 4));
        drain();

        // DOUT=15 saturation and sticky flag.
        chk("ovf_initial", ovf_c, 0);
        issue(2, vec2(16383, 16383), vec2(16383, 16383), ovec2(16383, 0), ovec2(16383, 0));
        drain();
        chk("ovf_set", ovf_c, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf_c, 0);
        issue(2, vec2(-16384, -16384), vec2(16383, -16383), ovec2(-16384, 0), ovec2(0, 16383));
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clear", ovf_c, 1);
        drain();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        issue(2, vec2(100, -20), vec2(0, 0), ovec2(80, 120), ovec2(0, 0));
        drain();
        chk("ovf_no_clip_stays_clear", ovf_c, 0);

        // Two frames with random gaps; counter starts fresh after reset.
        rst = 1'b1;
        sent = '{0, 0, 0};
        tick();
        rst = 1'b0;
        tick();
        for (int n = 0; n < 2 * NBLK; n++) issue_rand(0, 3);
        drain();

        // Random traffic: back-to-back then bursty, all three configurations.
        for (int n = 0; n < 40; n++) issue_rand(0, 0);
        for (int n = 0; n < 40; n++) issue_rand(0, (n % 8 < 5) ? 0 : 3);
        for (int n = 0; n < 24; n++) issue_rand(1, 2);
        for (int n = 0; n < 24; n++) issue_rand(2, 1);
        drain();

        chk("ovf_never_default", ovf_a, 0);
        chk("ovf_never_shift1", ovf_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
